instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus beat width in bits.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, Sysbus tag width.
REQ-003 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports bus_reqcyc out 1, bus_req out 64, bus_reqtag out BUS_TAG_WIDTH, bus_reqack in 1, for the read-request phase.
REQ-008 SHALL have ports bus_respcyc in 1, bus_resp in 64, bus_resptag in BUS_TAG_WIDTH, bus_respack out 1, for the response beats.
REQ-009 SHALL have ports redirect_valid in 1 and redirect_pc in 64, for a fetch restart (branch/jump).
REQ-010 SHALL have ports ins_valid out 1, ins out 32, ins_pc out 64, ins_ready in 1, for the decoder side.

Function
REQ-011 SHALL keep a 32-entry x (32b ins + 64b pc) FIFO, with 6-bit count, 5-bit wrapping rd/wr pointers.
REQ-012 SHALL keep fetch_pc, a 64-bit line address, with bits [5:0] zero; SHALL keep skip, 4 bits, the number of leading words to drop in the current line.
REQ-013 SHALL implement FSM states IDLE, REQ, RESP, DROP.
REQ-014 IDLE->REQ SHALL happen when free slots (32-count) >= 16 and no redirect is present.
REQ-015 REQ SHALL drive bus_reqcyc=1, bus_req=fetch_pc, and bus_reqtag={SYSBUS_READ, SYSBUS_MEMORY, zero fill} per Sysbus.defs, held stable until bus_reqack; on ack the FSM SHALL go to RESP.
REQ-016 RESP SHALL assert bus_respack=bus_respcyc, and each accepted beat SHALL be one 64-bit word; the 8th beat SHALL end the line.
REQ-017 Each beat SHALL push word data[31:0] first and then data[63:32], with pc = fetch_pc + 8*beat + 0 and +4; words with index < skip SHALL be discarded (1 or 2 pushes per beat).
REQ-018 After beat 8, the FSM SHALL set fetch_pc += 64 and skip = 0, then go to IDLE.
REQ-019 ins_valid SHALL be count != 0; ins and ins_pc SHALL be the head entry; pop SHALL happen on ins_valid & ins_ready.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; count SHALL never exceed 32, and no overflow check is needed because 16 free slots are reserved before each request.
REQ-021 On redirect_valid, the FIFO SHALL be flushed the next cycle (count=0, pointers equal), with fetch_pc = {redirect_pc[63:6], 6'b0} and skip = redirect_pc[5:2].
REQ-022 A redirect in IDLE SHALL go to IDLE (a request is issued the next eligible cycle); a redirect in REQ SHALL keep the request asserted until ack and then go to DROP; a redirect in RESP SHALL go to DROP.
REQ-023 DROP SHALL ack and discard the remaining beats of the outstanding line without pushing, then go to IDLE with the redirected fetch_pc intact.
REQ-024 A redirect SHALL override a same-cycle push/pop; the concurrent ins handshake SHALL count as flushed.
REQ-025 A later redirect during DROP SHALL only update fetch_pc and skip.
REQ-026 redirect_pc[1:0] SHALL be ignored (instructions are word aligned).

Reset
REQ-027 Reset SHALL force state=IDLE, count=0, pointers=0, beat counter=0, fetch_pc = RESET_PC with [5:0] cleared, and skip = RESET_PC[5:2].
REQ-028 During reset, outputs SHALL be bus_reqcyc=0, bus_respack=0, ins_valid=0, bus_req=0, and ins/ins_pc=0.
REQ-029 Reset asserted mid-line SHALL abandon the line immediately, with no DROP phase.

Verification
REQ-030 Reset with RESET_PC=0x1000, bus_reqack after 3 cycles, 8 beats, ins_ready=1 -> one request to 0x1000; ins_pc runs 0x1000..0x103C in order, low word first.
REQ-031 ins_ready=0 permanently -> after 2 lines count=32 with no third request; then ins_ready=1 for 16 pops -> the third request is issued to 0x1080.
REQ-032 redirect_pc=0x2018 in IDLE -> request to 0x2000; the first ins_pc is 0x2018; 10 instructions are pushed from that line.
REQ-033 redirect at beat 3 of RESP -> beats 4-8 are acked and not pushed; the FIFO is empty; the next request goes to the redirect line.
REQ-034 redirect coincides with pop and push -> count=0 the next cycle and ins_valid=0.
REQ-035 reset pulse during RESP at beat 5 -> outputs match REQ-028 within the same cycle; after release the request goes to the RESET_PC line.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: fetches 64-byte lines over Sysbus and buffers word-aligned
// instructions with their PCs for the decoder, restarting on branch/jump redirects.
module instr_fetch_queue #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter logic [63:0] RESET_PC       = 64'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      ins_valid,
    output logic [31:0]               ins,
    output logic [63:0]               ins_pc,
    input  logic                      ins_ready
);

    localparam logic                     SYSBUS_READ   = 1'b1;
    localparam logic [3:0]               SYSBUS_MEMORY = 4'b0001;
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG      =
        {SYSBUS_READ, SYSBUS_MEMORY, {(BUS_TAG_WIDTH-5){1'b0}}};

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDrop} state_e;

    state_e      state_q;
    logic [63:0] fetch_pc_q;
    logic [63:0] line_pc_q;
    logic [3:0]  skip_q;
    logic [2:0]  beat_q;
    logic        redirected_q;
    logic [5:0]  count_q;
    logic [4:0]  rd_ptr_q;
    logic [4:0]  wr_ptr_q;
    logic [31:0] mem_ins [32];
    logic [63:0] mem_pc  [32];

    logic [63:0] redirect_line;
    logic [63:0] beat_pc;
    logic        beat_in;
    logic        last_beat;
    logic        keep_lo;
    logic        keep_hi;
    logic [1:0]  push_n;
    logic        pop;
    logic [31:0] first_ins;
    logic [63:0] first_pc;
    logic [4:0]  wr_ptr_nx;
    logic        unused_bits;

    assign redirect_line = {redirect_pc[63:6], 6'b0};
    assign beat_pc       = line_pc_q + {58'b0, beat_q, 3'b0};
    assign beat_in       = (state_q == StResp) && bus_respcyc;
    assign last_beat     = (beat_q == 3'd7);

    // Word index within the line is {beat, half}; words before skip are dropped.
    // A redirect in the same cycle wins over any push.
    assign keep_lo   = beat_in && !redirect_valid && ({beat_q, 1'b0} >= skip_q);
    assign keep_hi   = beat_in && !redirect_valid && ({beat_q, 1'b1} >= skip_q);
    assign push_n    = {1'b0, keep_lo} + {1'b0, keep_hi};
    assign pop       = ins_valid && ins_ready;
    assign first_ins = keep_lo ? bus_resp[31:0] : bus_resp[63:32];
    assign first_pc  = keep_lo ? beat_pc : beat_pc + 64'd4;
    assign wr_ptr_nx = wr_ptr_q + 5'd1;

    assign unused_bits = ^{bus_resptag, redirect_pc[1:0]};

    // keep_hi is set whenever anything is pushed; keep_lo adds the second slot.
    always_ff @(posedge clk) begin
        if (keep_hi) begin
            mem_ins[wr_ptr_q] <= first_ins;
            mem_pc[wr_ptr_q]  <= first_pc;
        end
        if (keep_lo) begin
            mem_ins[wr_ptr_nx] <= bus_resp[63:32];
            mem_pc[wr_ptr_nx]  <= beat_pc + 64'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 6'd0;
            rd_ptr_q <= 5'd0;
            wr_ptr_q <= 5'd0;
        end else if (redirect_valid) begin
            count_q  <= 6'd0;
            rd_ptr_q <= 5'd0;
            wr_ptr_q <= 5'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q + {3'b0, push_n};
            rd_ptr_q <= rd_ptr_q + {4'b0, pop};
            count_q  <= count_q + {4'b0, push_n} - {5'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            fetch_pc_q   <= {RESET_PC[63:6], 6'b0};
            skip_q       <= RESET_PC[5:2];
            line_pc_q    <= 64'd0;
            beat_q       <= 3'd0;
            redirected_q <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc_q <= redirect_line;
                skip_q     <= redirect_pc[5:2];
            end
            case (state_q)
                StIdle: begin
                    // Issue only with room for a whole line: 16 free slots.
                    if (!redirect_valid && (count_q <= 6'd16)) begin
                        state_q      <= StReq;
                        line_pc_q    <= fetch_pc_q;
                        redirected_q <= 1'b0;
                    end
                end
                StReq: begin
                    if (redirect_valid) begin
                        redirected_q <= 1'b1;
                    end
                    if (bus_reqack) begin
                        beat_q  <= 3'd0;
                        state_q <= (redirected_q || redirect_valid) ? StDrop : StResp;
                    end
                end
                StResp: begin
                    if (bus_respcyc) begin
                        beat_q <= beat_q + 3'd1;
                        if (last_beat) begin
                            state_q <= StIdle;
                            if (!redirect_valid) begin
                                fetch_pc_q <= line_pc_q + 64'd64;
                                skip_q     <= 4'd0;
                            end
                        end else if (redirect_valid) begin
                            state_q <= StDrop;
                        end
                    end else if (redirect_valid) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (bus_respcyc) begin
                        beat_q <= beat_q + 3'd1;
                        if (last_beat) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_reqcyc  = (state_q == StReq);
    assign bus_req     = bus_reqcyc ? line_pc_q : 64'd0;
    assign bus_reqtag  = bus_reqcyc ? READ_TAG : '0;
    assign bus_respack = bus_respcyc && ((state_q == StResp) || (state_q == StDrop));

    assign ins_valid = (count_q != 6'd0);
    assign ins       = ins_valid ? mem_ins[rd_ptr_q] : 32'd0;
    assign ins_pc    = ins_valid ? mem_pc[rd_ptr_q] : 64'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a small Sysbus memory model serves lines and a
// scoreboard checks every instruction handed to the decoder, in order.
`timescale 1ns/1ps
module tb_instr_fetch_queue;

    localparam logic [63:0] RESET_PC = 64'h1000;
    localparam logic [12:0] READ_TAG = 13'h1100;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [63:0] ins_pc;
    logic        ins_ready;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .RESET_PC      (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_reqcyc    (bus_reqcyc),
        .bus_req       (bus_req),
        .bus_reqtag    (bus_reqtag),
        .bus_reqack    (bus_reqack),
        .bus_respcyc   (bus_respcyc),
        .bus_resp      (bus_resp),
        .bus_resptag   (bus_resptag),
        .bus_respack   (bus_respack),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ins_valid     (ins_valid),
        .ins           (ins),
        .ins_pc        (ins_pc),
        .ins_ready     (ins_ready)
    );

    int          tests    = 0;
    int          failures = 0;
    int          popped   = 0;
    logic        saw_req;
    logic [31:0] exp_ins_q[$];
    logic [63:0] exp_pc_q[$];

    function automatic logic [31:0] word_of(input logic [63:0] pc);
        return {pc[15:0] ^ 16'hC3A5, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_clear();
        exp_ins_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic sb_push(input logic [63:0] pc);
        exp_ins_q.push_back(word_of(pc));
        exp_pc_q.push_back(pc);
    endtask

    task automatic wait_req(input string tag, input logic [63:0] exp_addr);
        int n = 0;
        while (bus_reqcyc !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, {63'b0, bus_reqcyc}, 64'd1);
        check({tag, "_req_addr"}, bus_req, exp_addr);
        check({tag, "_req_tag"}, {51'b0, bus_reqtag}, {51'b0, READ_TAG});
    endtask

    task automatic ack_req(input int delay, input logic [63:0] addr);
        repeat (delay) tick();
        check("req_held", bus_req, addr);
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] line, input int b, input int skip,
                             input bit push_en);
        logic [63:0] pc = line + 64'(8 * b);
        bus_respcyc = 1'b1;
        bus_resp    = {word_of(pc + 64'd4), word_of(pc)};
        bus_resptag = READ_TAG;
        if (push_en) begin
            if (2 * b >= skip) sb_push(pc);
            if (2 * b + 1 >= skip) sb_push(pc + 64'd4);
        end
        #1;
        check("respack", {63'b0, bus_respack}, 64'd1);
        @(posedge clk);
        #1;
        bus_respcyc = 1'b0;
    endtask

    // Decoder side: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && ins_valid && ins_ready && !redirect_valid) begin
            tests++;
            assert (exp_pc_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_ins: got pc %0h expected none", ins_pc);
            end
            if (exp_pc_q.size() > 0) begin
                check("ins_pc", ins_pc, exp_pc_q.pop_front());
                check("ins", {32'b0, ins}, {32'b0, exp_ins_q.pop_front()});
                popped++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b1;
        bus_resp       = '0;
        bus_resptag    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ins_ready      = 1'b1;
        saw_req        = 1'b0;
        repeat (2) tick();
        check("rst_reqcyc", {63'b0, bus_reqcyc}, 64'd0);
        check("rst_respack", {63'b0, bus_respack}, 64'd0);
        check("rst_ins_valid", {63'b0, ins_valid}, 64'd0);
        check("rst_bus_req", bus_req, 64'd0);
        check("rst_ins", {32'b0, ins}, 64'd0);
        check("rst_ins_pc", ins_pc, 64'd0);
        bus_respcyc = 1'b0;
        reset       = 1'b0;

        // First line after reset, streamed straight to the decoder.
        wait_req("l1000", 64'h1000);
        ack_req(3, 64'h1000);
        for (int b = 0; b < 8; b++) send_beat(64'h1000, b, 0, 1'b1);
        repeat (20) tick();
        check("l1000_popped", 64'(popped), 64'd16);
        check("l1000_sb_empty", 64'(exp_pc_q.size()), 64'd0);

        // Stalled decoder: two lines fill the FIFO, a third waits for 16 free slots.
        reset = 1'b1;
        sb_clear();
        popped    = 0;
        ins_ready = 1'b0;
        tick();
        reset = 1'b0;
        wait_req("full_a", 64'h1000);
        ack_req(1, 64'h1000);
        for (int b = 0; b < 8; b++) send_beat(64'h1000, b, 0, 1'b1);
        wait_req("full_b", 64'h1040);
        ack_req(1, 64'h1040);
        for (int b = 0; b < 8; b++) send_beat(64'h1040, b, 0, 1'b1);
        repeat (20) begin
            tick();
            if (bus_reqcyc) saw_req = 1'b1;
        end
        check("full_no_third_req", {63'b0, saw_req}, 64'd0);
        check("full_ins_valid", {63'b0, ins_valid}, 64'd1);
        ins_ready = 1'b1;
        repeat (16) tick();
        ins_ready = 1'b0;
        check("full_popped", 64'(popped), 64'd16);
        wait_req("full_c", 64'h1080);

        // Redirect while idle, with the low PC bits set to check they are ignored.
        reset = 1'b1;
        sb_clear();
        popped         = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h201B;
        ins_ready      = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        redirect_valid = 1'b0;
        check("idle_redirect_hold", {63'b0, bus_reqcyc}, 64'd0);
        wait_req("l2000", 64'h2000);
        ack_req(2, 64'h2000);
        for (int b = 0; b < 8; b++) send_beat(64'h2000, b, 6, 1'b1);
        repeat (20) tick();
        check("l2000_popped", 64'(popped), 64'd10);
        check("l2000_sb_empty", 64'(exp_pc_q.size()), 64'd0);

        // Redirect at beat 3: rest of the line is acked and dropped, then refetch.
        wait_req("l2040", 64'h2040);
        ins_ready = 1'b0;
        popped    = 0;
        ack_req(2, 64'h2040);
        send_beat(64'h2040, 0, 0, 1'b1);
        send_beat(64'h2040, 1, 0, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3004;
        sb_clear();
        send_beat(64'h2040, 2, 0, 1'b0);
        redirect_valid = 1'b0;
        check("resp_redirect_flush", {63'b0, ins_valid}, 64'd0);
        for (int b = 3; b < 8; b++) begin
            if (b == 5) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h3044;
            end
            send_beat(64'h2040, b, 0, 1'b0);
            redirect_valid = 1'b0;
            check("drop_no_req", {63'b0, bus_reqcyc}, 64'd0);
        end
        check("drop_empty", {63'b0, ins_valid}, 64'd0);
        wait_req("l3040", 64'h3040);
        ins_ready = 1'b1;
        ack_req(1, 64'h3040);
        for (int b = 0; b < 8; b++) send_beat(64'h3040, b, 1, 1'b1);
        repeat (20) tick();
        check("l3040_popped", 64'(popped), 64'd15);
        check("l3040_sb_empty", 64'(exp_pc_q.size()), 64'd0);

        // Redirect coinciding with a push and a pop.
        wait_req("l3080", 64'h3080);
        ack_req(0, 64'h3080);
        send_beat(64'h3080, 0, 0, 1'b1);
        check("pre_redirect_valid", {63'b0, ins_valid}, 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        sb_clear();
        send_beat(64'h3080, 1, 0, 1'b0);
        redirect_valid = 1'b0;
        check("pushpop_redirect_valid", {63'b0, ins_valid}, 64'd0);
        for (int b = 2; b < 8; b++) send_beat(64'h3080, b, 0, 1'b0);
        wait_req("l4000", 64'h4000);

        // Reset mid-line at beat 5: outputs clear at once, line is abandoned.
        ack_req(1, 64'h4000);
        for (int b = 0; b < 4; b++) send_beat(64'h4000, b, 0, 1'b1);
        bus_respcyc = 1'b1;
        bus_resp    = {word_of(64'h4024), word_of(64'h4020)};
        #1;
        reset = 1'b1;
        #1;
        check("midrst_reqcyc", {63'b0, bus_reqcyc}, 64'd0);
        check("midrst_respack", {63'b0, bus_respack}, 64'd0);
        check("midrst_ins_valid", {63'b0, ins_valid}, 64'd0);
        check("midrst_bus_req", bus_req, 64'd0);
        check("midrst_ins", {32'b0, ins}, 64'd0);
        check("midrst_ins_pc", ins_pc, 64'd0);
        sb_clear();
        tick();
        bus_respcyc = 1'b0;
        reset       = 1'b0;
        wait_req("after_rst", 64'h1000);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
